wash_coin_acceptor: RTL and testbench
=====================================

// Module: wash_coin_acceptor
// PURPOSE
//  Payment front-end directly upstream of the washing-machine FSM. Accumulates coins
//  (units 1/2/5), compares credit to single- or double-wash price, issues a 1-cycle
//  coin_deposit_o pulse plus a held double_wash_o level to the FSM, and returns change.
//  Supports cancel/refund. Locks out coins while a cycle runs, until done_i or off_interrupt_i.
// PARAMETERS
//  CREDIT_W     4   credit register width; MAX_CREDIT = 2**CREDIT_W-1
//  PRICE_SINGLE 4   single-wash price in coin units
//  PRICE_DOUBLE 6   double-wash price in coin units (>= PRICE_SINGLE, <= MAX_CREDIT)
//  TIMEOUT_CYC  15  idle cycles in COLLECT before auto-refund (TIMEOUT_REFUND_EN only)
// PORTS
//  clk              in   1         clock, rising edge
//  rst              in   1         asynchronous reset, active-low
//  coin_valid_i     in   1         coin strobe, 1 cycle per coin
//  coin_value_i     in   2         00=1, 01=2, 10=5, 11=invalid
//  double_sel_i     in   1         1 = customer selects double wash
//  cancel_i         in   1         request refund of current credit
//  done_i           in   1         FSM done pulse; releases lock
//  off_interrupt_i  in   1         FSM spin-interrupt abort; releases lock
//  coin_deposit_o   out  1         1-cycle pulse: wash paid, start FSM
//  double_wash_o    out  1         held from vend until lock release
//  coin_reject_o    out  1         1-cycle pulse: coin not accepted
//  change_valid_o   out  1         1-cycle pulse; change_o valid
//  change_o         out  CREDIT_W  change amount (0 when change_valid_o=0)
//  refund_valid_o   out  1         1-cycle pulse; refund_o valid
//  refund_o         out  CREDIT_W  refund amount (0 when refund_valid_o=0)
//  credit_o         out  CREDIT_W  current registered credit
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, credit=0, timer=0, all outputs 0.
//  price = double_sel_i ? PRICE_DOUBLE : PRICE_SINGLE, evaluated combinationally each cycle.
//  Coin accepted in cycle N -> credit_o updated at N+1; coin_reject_o is registered, high in N+1.
//  Reject when: value code 11; credit+value > MAX_CREDIT; state not IDLE/COLLECT;
//  cancel_i high in the same cycle. Rejected coins leave credit unchanged.
//  States:
//   IDLE:    accepted coin -> COLLECT. cancel_i ignored (credit is 0).
//   COLLECT: credit >= price -> VEND (takes priority over coins that cycle; those coins rejected).
//            cancel_i=1 -> REFUND. Otherwise stays and accepts coins.
//   VEND:    1 cycle. coin_deposit_o=1; double_wash_o<=double_sel_i latched;
//            credit<=credit-price. Remainder>0 -> CHANGE, else -> LOCKED.
//   CHANGE:  1 cycle. change_valid_o=1, change_o=credit; credit<=0 -> LOCKED.
//   REFUND:  1 cycle. refund_valid_o=1, refund_o=credit; credit<=0 -> IDLE.
//   LOCKED:  all coins rejected, cancel_i ignored. done_i|off_interrupt_i -> IDLE,
//            clearing double_wash_o.
//  Double-sel toggled in COLLECT re-evaluates the price; only the value at VEND entry counts.
//  Outputs coin_deposit_o/change_valid_o/refund_valid_o are registered, mutually exclusive.
//  Reset mid-operation: credit lost, no refund pulse, return to IDLE.
// CONFIGURATION
//  TIMEOUT_REFUND_EN defined: CREDIT_W-wide inactivity timer runs in COLLECT, cleared on any
//   accepted coin. Timer reaching TIMEOUT_CYC -> REFUND (same as cancel). Timer held 0 elsewhere.
//  TIMEOUT_REFUND_EN undefined: no timer; credit held in COLLECT indefinitely.
// TESTING
//  double_sel=0, coins 2,2 -> coin_deposit_o 1 pulse, no change_valid_o, credit_o=0, LOCKED.
//  double_sel=1, coins 5,2 -> coin_deposit_o, double_wash_o=1, change_valid_o with change_o=1.
//  Coin 5, double_sel=1, then cancel_i -> refund_valid_o with refund_o=5, back to IDLE.
//  Coin in LOCKED, or code 11 -> coin_reject_o=1, credit unchanged; done_i -> IDLE, double_wash_o=0.
//  Coin 2 same cycle as cancel_i in COLLECT (credit 2) -> reject, refund_o=2.
//  TIMEOUT_REFUND_EN: coin 1, idle 15 cycles -> refund_o=1; reset mid-COLLECT -> credit_o=0, no pulse.

Source files
------------

// File: rtl/wash_coin_acceptor.sv
// Coin front-end for the washing-machine FSM: accumulates credit, vends single/double wash,
// pays change, refunds on cancel and locks out coins while a wash runs. Optional macro: TIMEOUT_REFUND_EN.
module wash_coin_acceptor #(
  parameter int CREDIT_W     = 4,
  parameter int PRICE_SINGLE = 4,
  parameter int PRICE_DOUBLE = 6,
  parameter int TIMEOUT_CYC  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid_i,
  input  logic [1:0]          coin_value_i,
  input  logic                double_sel_i,
  input  logic                cancel_i,
  input  logic                done_i,
  input  logic                off_interrupt_i,
  output logic                coin_deposit_o,
  output logic                double_wash_o,
  output logic                coin_reject_o,
  output logic                change_valid_o,
  output logic [CREDIT_W-1:0] change_o,
  output logic                refund_valid_o,
  output logic [CREDIT_W-1:0] refund_o,
  output logic [CREDIT_W-1:0] credit_o,
  output logic [2:0]          state_o
);

  // Strobe semantics: no back-pressure. Every coin_valid_i cycle is answered one cycle later,
  // either by a credit_o update (accepted) or by a one-cycle coin_reject_o pulse.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_VEND    = 3'd2,
    S_CHANGE  = 3'd3,
    S_REFUND  = 3'd4,
    S_LOCKED  = 3'd5
  } state_e;

`ifdef TIMEOUT_REFUND_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  localparam logic [CREDIT_W:0]   MAX_SUM     = (CREDIT_W+1)'(2**CREDIT_W - 1);
  localparam logic [CREDIT_W-1:0] P_SINGLE    = CREDIT_W'(PRICE_SINGLE);
  localparam logic [CREDIT_W-1:0] P_DOUBLE    = CREDIT_W'(PRICE_DOUBLE);
  localparam logic [CREDIT_W-1:0] TIMEOUT_LIM = CREDIT_W'(TIMEOUT_CYC);

  state_e              state_q;
  logic [CREDIT_W-1:0] credit_q, change_q, refund_q, timer_q, timer_d;
  logic                coin_deposit_q, double_wash_q, coin_reject_q;
  logic                change_valid_q, refund_valid_q;
  logic [CREDIT_W-1:0] price, vend_price, remainder;
  logic [CREDIT_W:0]   coin_amt, credit_sum;
  logic                go_vend, go_refund, timed_out, accept;

  always_comb begin
    price      = double_sel_i ? P_DOUBLE : P_SINGLE;
    // The selection latched on VEND entry fixes the price actually charged.
    vend_price = double_wash_q ? P_DOUBLE : P_SINGLE;
    remainder  = credit_q - vend_price;
    case (coin_value_i)
      2'b00:   coin_amt = (CREDIT_W+1)'(1);
      2'b01:   coin_amt = (CREDIT_W+1)'(2);
      2'b10:   coin_amt = (CREDIT_W+1)'(5);
      default: coin_amt = '0;
    endcase
    credit_sum = {1'b0, credit_q} + coin_amt;
    timed_out  = TIMER_EN && (timer_q == TIMEOUT_LIM);
    go_vend    = (state_q == S_COLLECT) && (credit_q >= price);
    go_refund  = (state_q == S_COLLECT) && !go_vend && (cancel_i || timed_out);
    accept     = coin_valid_i && (coin_value_i != 2'b11) && !cancel_i && !go_vend && !go_refund &&
                 ((state_q == S_IDLE) || (state_q == S_COLLECT)) && (credit_sum <= MAX_SUM);
    timer_d    = '0;
    if (TIMER_EN && (state_q == S_COLLECT) && !go_vend && !go_refund && !accept)
      timer_d = timer_q + CREDIT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      credit_q       <= '0;
      timer_q        <= '0;
      coin_deposit_q <= 1'b0;
      double_wash_q  <= 1'b0;
      coin_reject_q  <= 1'b0;
      change_valid_q <= 1'b0;
      change_q       <= '0;
      refund_valid_q <= 1'b0;
      refund_q       <= '0;
    end else begin
      timer_q        <= timer_d;
      coin_reject_q  <= coin_valid_i && !accept;
      coin_deposit_q <= 1'b0;
      change_valid_q <= 1'b0;
      change_q       <= '0;
      refund_valid_q <= 1'b0;
      refund_q       <= '0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            credit_q <= credit_sum[CREDIT_W-1:0];
            state_q  <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (go_vend) begin
            coin_deposit_q <= 1'b1;
            double_wash_q  <= double_sel_i;
            state_q        <= S_VEND;
          end else if (go_refund) begin
            refund_valid_q <= 1'b1;
            refund_q       <= credit_q;
            state_q        <= S_REFUND;
          end else if (accept) begin
            credit_q <= credit_sum[CREDIT_W-1:0];
          end
        end
        S_VEND: begin
          credit_q <= remainder;
          if (remainder != '0) begin
            change_valid_q <= 1'b1;
            change_q       <= remainder;
            state_q        <= S_CHANGE;
          end else begin
            state_q <= S_LOCKED;
          end
        end
        S_CHANGE: begin
          credit_q <= '0;
          state_q  <= S_LOCKED;
        end
        S_REFUND: begin
          credit_q <= '0;
          state_q  <= S_IDLE;
        end
        S_LOCKED: begin
          if (done_i || off_interrupt_i) begin
            double_wash_q <= 1'b0;
            state_q       <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign coin_deposit_o = coin_deposit_q;
  assign double_wash_o  = double_wash_q;
  assign coin_reject_o  = coin_reject_q;
  assign change_valid_o = change_valid_q;
  assign change_o       = change_q;
  assign refund_valid_o = refund_valid_q;
  assign refund_o       = refund_q;
  assign credit_o       = credit_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_wash_coin_acceptor.sv
// Bench for wash_coin_acceptor: directed payment scenarios plus random traffic, checked every
// cycle against a session/timeline model of the coin acceptor.
module tb_wash_coin_acceptor;

  localparam int CW = 4;
  localparam int PS = 4;
  localparam int PD = 6;
  localparam int TO = 15;
  localparam int MAXC = 2**CW - 1;

  typedef struct packed {
    logic          dep;
    logic          dw;
    logic          rej;
    logic          chg_v;
    logic [CW-1:0] chg;
    logic          ref_v;
    logic [CW-1:0] refund;
    logic [CW-1:0] credit;
  } exp_t;
  localparam int EW = $bits(exp_t);

  // One scripted future cycle of a vend or refund sequence.
  typedef struct {
    int credit;
    int chg;
    bit lock;
  } pend_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          coin_valid = 1'b0;
  logic [1:0]    coin_value = 2'b00;
  logic          double_sel = 1'b0;
  logic          cancel = 1'b0;
  logic          done = 1'b0;
  logic          off_int = 1'b0;
  logic          coin_deposit, double_wash, coin_reject, change_valid, refund_valid;
  logic [CW-1:0] change_amt, refund_amt, credit;
  logic [2:0]    state_dbg;

  wash_coin_acceptor #(.CREDIT_W(CW), .PRICE_SINGLE(PS), .PRICE_DOUBLE(PD), .TIMEOUT_CYC(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .coin_valid_i    (coin_valid),
    .coin_value_i    (coin_value),
    .double_sel_i    (double_sel),
    .cancel_i        (cancel),
    .done_i          (done),
    .off_interrupt_i (off_int),
    .coin_deposit_o  (coin_deposit),
    .double_wash_o   (double_wash),
    .coin_reject_o   (coin_reject),
    .change_valid_o  (change_valid),
    .change_o        (change_amt),
    .refund_valid_o  (refund_valid),
    .refund_o        (refund_amt),
    .credit_o        (credit),
    .state_o         (state_dbg)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  pend_t         pend_q[$];
  int            checks = 0;
  int            errors = 0;
  string         phase = "reset";
  int            m_credit = 0;
  int            m_idle = 0;
  bit            m_locked = 1'b0;
  bit            m_dw = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s/%s: observed %0d, expected %0d (t=%0t)", phase, tag, obs, exp, $time);
    end
  endtask

  function automatic int coin_units(input logic [1:0] code);
    case (code)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 5;
      default: return 0;
    endcase
  endfunction

  // Reference: a session is open while credit > 0; vends and refunds run as scripted timelines.
  task automatic model_step();
    exp_t  e;
    pend_t p;
    int    price, v, rem;
    bit    timeout, acc;
    e = '0;
    if (pend_q.size() > 0) begin
      p = pend_q.pop_front();
      m_credit = p.credit;
      e.chg_v  = (p.chg > 0);
      e.chg    = CW'(p.chg);
      if (p.lock) m_locked = 1'b1;
      e.rej = coin_valid;
    end else if (m_locked) begin
      e.rej = coin_valid;
      if (done || off_int) begin
        m_locked = 1'b0;
        m_dw     = 1'b0;
      end
    end else begin
      price = double_sel ? PD : PS;
      v     = coin_units(coin_value);
`ifdef TIMEOUT_REFUND_EN
      timeout = (m_idle == TO);
`else
      timeout = 1'b0;
`endif
      if (m_credit > 0 && m_credit >= price) begin
        e.dep  = 1'b1;
        e.rej  = coin_valid;
        m_dw   = double_sel;
        rem    = m_credit - price;
        m_idle = 0;
        pend_q.push_back('{credit: rem, chg: rem, lock: (rem == 0)});
        if (rem > 0) pend_q.push_back('{credit: 0, chg: 0, lock: 1'b1});
      end else if (m_credit > 0 && (cancel || timeout)) begin
        e.ref_v  = 1'b1;
        e.refund = CW'(m_credit);
        e.rej    = coin_valid;
        m_idle   = 0;
        pend_q.push_back('{credit: 0, chg: 0, lock: 1'b0});
      end else begin
        acc = coin_valid && (v > 0) && !cancel && (m_credit + v <= MAXC);
        if (acc) begin
          m_credit += v;
          m_idle = 0;
        end else if (m_credit > 0) begin
          m_idle++;
        end
        e.rej = coin_valid && !acc;
      end
    end
    e.dw     = m_dw;
    e.credit = CW'(m_credit);
    exp_q.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    check_eq("exp_q_size", exp_q.size(), 1);
    if (exp_q.size() == 0) return;
    e = exp_t'(exp_q.pop_front());
    check_eq("coin_deposit_o", coin_deposit, e.dep);
    check_eq("double_wash_o", double_wash, e.dw);
    check_eq("coin_reject_o", coin_reject, e.rej);
    check_eq("change_valid_o", change_valid, e.chg_v);
    check_eq("change_o", change_amt, e.chg);
    check_eq("refund_valid_o", refund_valid, e.ref_v);
    check_eq("refund_o", refund_amt, e.refund);
    check_eq("credit_o", credit, e.credit);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic clear_inputs();
    coin_valid = 1'b0;
    cancel     = 1'b0;
    done       = 1'b0;
    off_int    = 1'b0;
  endtask

  task automatic coin(input logic [1:0] code, input logic sel);
    coin_valid = 1'b1;
    coin_value = code;
    double_sel = sel;
    step();
    coin_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic release_lock(input bit use_off);
    if (use_off) off_int = 1'b1;
    else done = 1'b1;
    step();
    clear_inputs();
  endtask

  task automatic check_all_zero();
    check_eq("rst_deposit", coin_deposit, 0);
    check_eq("rst_double", double_wash, 0);
    check_eq("rst_reject", coin_reject, 0);
    check_eq("rst_change_v", change_valid, 0);
    check_eq("rst_change", change_amt, 0);
    check_eq("rst_refund_v", refund_valid, 0);
    check_eq("rst_refund", refund_amt, 0);
    check_eq("rst_credit", credit, 0);
    check_eq("rst_state", state_dbg, 0);
  endtask

  initial begin
    #12;
    check_all_zero();
    @(negedge clk);
    rst = 1'b1;

    phase = "single_2_2";
    coin(2'b01, 1'b0);
    coin(2'b01, 1'b0);
    idle(3);
    release_lock(1'b0);

    phase = "double_5_2";
    coin(2'b10, 1'b1);
    coin(2'b01, 1'b1);
    idle(4);
    release_lock(1'b0);

    phase = "cancel_5";
    coin(2'b10, 1'b1);
    cancel = 1'b1;
    step();
    idle(2);

    phase = "locked_reject";
    coin(2'b01, 1'b0);
    coin(2'b11, 1'b0);
    coin(2'b01, 1'b0);
    idle(2);
    coin(2'b00, 1'b0);
    coin(2'b11, 1'b0);
    release_lock(1'b1);
    idle(1);

    phase = "coin_cancel";
    coin(2'b01, 1'b1);
    coin_valid = 1'b1;
    coin_value = 2'b01;
    cancel     = 1'b1;
    step();
    idle(2);

    phase = "reset_mid_collect";
    coin(2'b01, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero();
    exp_q.delete();
    pend_q.delete();
    m_credit = 0;
    m_idle   = 0;
    m_locked = 1'b0;
    m_dw     = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(2);

`ifdef TIMEOUT_REFUND_EN
    phase = "timeout";
    coin(2'b00, 1'b0);
    idle(TO + 3);
`endif

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      coin_valid = ($urandom_range(0, 99) < 40);
      coin_value = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) double_sel = ~double_sel;
      cancel  = ($urandom_range(0, 99) < 6);
      done    = ($urandom_range(0, 99) < 8);
      off_int = ($urandom_range(0, 99) < 3);
      step();
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
